// File: rtl/vram_cpu_port.sv
`default_nettype none
// ============================================================================
// Module   : vram_cpu_port
// Brief    : CPU-side single-word read/write controller for the four GPU VRAMs
//            (VRAM32, VRAM322, VRAM8, VRAMSPR), start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module vram_cpu_port #(
    parameter int SIZE32  = 1056,
    parameter int SIZE322 = 1056,
    parameter int SIZE8   = 8194,
    parameter int SIZESPR = 256
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        bus_start,
    input  logic        bus_we,
    input  logic [15:0] bus_addr,
    input  logic [31:0] bus_data,
    output logic [31:0] bus_q,
    output logic        bus_busy,
    output logic        bus_done,
    output logic [13:0] vram32_cpu_addr,
    output logic [31:0] vram32_cpu_d,
    output logic        vram32_cpu_we,
    input  logic [31:0] vram32_cpu_q,
    output logic [13:0] vram322_cpu_addr,
    output logic [31:0] vram322_cpu_d,
    output logic        vram322_cpu_we,
    input  logic [31:0] vram322_cpu_q,
    output logic [13:0] vram8_cpu_addr,
    output logic [7:0]  vram8_cpu_d,
    output logic        vram8_cpu_we,
    input  logic [7:0]  vram8_cpu_q,
    output logic [13:0] vramSPR_cpu_addr,
    output logic [8:0]  vramSPR_cpu_d,
    output logic        vramSPR_cpu_we,
    input  logic [8:0]  vramSPR_cpu_q
);

    localparam logic [14:0] c_size32  = 15'(SIZE32);
    localparam logic [14:0] c_size322 = 15'(SIZE322);
    localparam logic [14:0] c_size8   = 15'(SIZE8);
    localparam logic [14:0] c_sizespr = 15'(SIZESPR);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_we;
    logic [1:0]  r_sel;
    logic        r_in_range;

    logic        w_accept;
    logic [1:0]  w_sel;
    logic [14:0] w_off;
    logic        w_in_range;
    logic [31:0] w_rd_q;

    assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && bus_start;
    assign w_sel    = bus_addr[15:14];
    assign w_off    = {1'b0, bus_addr[13:0]};

    always_comb begin
        w_in_range = 1'b0;
        case (w_sel)
            2'b00:   w_in_range = (w_off < c_size32);
            2'b01:   w_in_range = (w_off < c_size322);
            2'b10:   w_in_range = (w_off < c_size8);
            default: w_in_range = (w_off < c_sizespr);
        endcase
    end

    always_comb begin
        w_rd_q = 32'd0;
        case (r_sel)
            2'b00:   w_rd_q = vram32_cpu_q;
            2'b01:   w_rd_q = vram322_cpu_q;
            2'b10:   w_rd_q = {24'd0, vram8_cpu_q};
            default: w_rd_q = {23'd0, vramSPR_cpu_q};
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: w_state_nxt = bus_start ? ST_ACCESS : ST_IDLE;
            ST_ACCESS:        w_state_nxt = r_we ? ST_DONE : ST_WAIT;
            ST_WAIT:          w_state_nxt = ST_DONE;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus_busy = (r_state == ST_ACCESS) || (r_state == ST_WAIT);
    assign bus_done = (r_state == ST_DONE);

    // Address/data/we are registered at acceptance so they are presented to the
    // selected VRAM throughout the ACCESS cycle; we self-clears one cycle later.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state          <= ST_IDLE;
            r_we             <= 1'b0;
            r_sel            <= 2'b00;
            r_in_range       <= 1'b0;
            bus_q            <= 32'd0;
            vram32_cpu_addr  <= 14'd0;
            vram32_cpu_d     <= 32'd0;
            vram32_cpu_we    <= 1'b0;
            vram322_cpu_addr <= 14'd0;
            vram322_cpu_d    <= 32'd0;
            vram322_cpu_we   <= 1'b0;
            vram8_cpu_addr   <= 14'd0;
            vram8_cpu_d      <= 8'd0;
            vram8_cpu_we     <= 1'b0;
            vramSPR_cpu_addr <= 14'd0;
            vramSPR_cpu_d    <= 9'd0;
            vramSPR_cpu_we   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            vram32_cpu_we  <= 1'b0;
            vram322_cpu_we <= 1'b0;
            vram8_cpu_we   <= 1'b0;
            vramSPR_cpu_we <= 1'b0;
            if (w_accept) begin
                r_we       <= bus_we;
                r_sel      <= w_sel;
                r_in_range <= w_in_range;
                case (w_sel)
                    2'b00: begin
                        vram32_cpu_addr <= bus_addr[13:0];
                        vram32_cpu_d    <= bus_data;
                        vram32_cpu_we   <= bus_we && w_in_range;
                    end
                    2'b01: begin
                        vram322_cpu_addr <= bus_addr[13:0];
                        vram322_cpu_d    <= bus_data;
                        vram322_cpu_we   <= bus_we && w_in_range;
                    end
                    2'b10: begin
                        vram8_cpu_addr <= bus_addr[13:0];
                        vram8_cpu_d    <= bus_data[7:0];
                        vram8_cpu_we   <= bus_we && w_in_range;
                    end
                    default: begin
                        vramSPR_cpu_addr <= bus_addr[13:0];
                        vramSPR_cpu_d    <= bus_data[8:0];
                        vramSPR_cpu_we   <= bus_we && w_in_range;
                    end
                endcase
            end
            if (r_state == ST_WAIT) begin
                bus_q <= r_in_range ? w_rd_q : 32'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/vram_cpu_port.md
Name: vram_cpu_port

Overview:
- CPU-side access controller for the GPU video memories: VRAM32, VRAM322, VRAM8 and VRAMSPR.
- Takes single-word read/write requests from the CPU bus using a start/busy/done handshake.
- Decodes the target memory and offset, drives the CPU port of the selected dual-port VRAM, and returns read data zero-extended to 32 bits.
- Sits upstream of the VRAMs. FSX reads the same memories on their GPU ports.

Parameters:
- SIZE32, 1056, word count of VRAM32; offsets >= this are out of range
- SIZE322, 1056, word count of VRAM322
- SIZE8, 8194, word count of VRAM8
- SIZESPR, 256, word count of VRAMSPR

Ports:
- clk  input  1  CPU clock; all state changes on the rising edge
- nreset  input  1  asynchronous, active-low reset
- bus_start  input  1  request strobe; sampled only in IDLE or DONE
- bus_we  input  1  1 = write, 0 = read; sampled with bus_start
- bus_addr  input  16  [15:14] select (00 = VRAM32, 01 = VRAM322, 10 = VRAM8, 11 = VRAMSPR); [13:0] word offset
- bus_data  input  32  write data; sampled with bus_start
- bus_q  output  32  read result; zero-extended; held until the next read completes
- bus_busy  output  1  high while a request is in flight
- bus_done  output  1  one-cycle completion pulse
- vram32_cpu_addr / vram322_cpu_addr  output  14  address to VRAM32 / VRAM322
- vram32_cpu_d / vram322_cpu_d  output  32  write data to VRAM32 / VRAM322
- vram32_cpu_we / vram322_cpu_we  output  1  write enable to VRAM32 / VRAM322
- vram32_cpu_q / vram322_cpu_q  input  32  registered read data (1-cycle latency)
- vram8_cpu_addr  output  14  address to VRAM8
- vram8_cpu_d  output  8  write data to VRAM8
- vram8_cpu_we  output  1  write enable to VRAM8
- vram8_cpu_q  input  8  registered read data from VRAM8
- vramSPR_cpu_addr  output  14  address to VRAMSPR
- vramSPR_cpu_d  output  9  write data to VRAMSPR
- vramSPR_cpu_we  output  1  write enable to VRAMSPR
- vramSPR_cpu_q  input  9  registered read data from VRAMSPR

Behaviour:
- Reset (async, nreset = 0): state = IDLE; bus_q = 0, bus_busy = 0, bus_done = 0; all *_cpu_addr = 0, *_cpu_d = 0, *_cpu_we = 0.
- Reset mid-operation drops the request: no done pulse, no write reaches VRAM after reset asserts.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE or DONE with bus_start = 1:
  - latch bus_we, select, offset and bus_data; go to ACCESS.
  - the range check is offset < size of the selected memory.
- IDLE or DONE with bus_start = 0: go to (or stay in) IDLE.
- ACCESS (one cycle):
  - the selected memory's cpu_addr = offset; its cpu_d = bus_data truncated to its width (32 / 32 / 8 / 9 LSBs).
  - cpu_we = 1 on the selected memory only, and only if it is a write and in range; all other we = 0.
  - next state is DONE for a write, WAIT for a read.
- WAIT (one cycle): the selected q is valid. At the clock edge, bus_q <= zero-extended q if in range, else 0. Next state is DONE.
- DONE (one cycle): bus_done = 1, bus_busy = 0.
- bus_busy = 1 in ACCESS and WAIT, 0 in IDLE and DONE.
- Latency, with start sampled in cycle N:
  - write: we high in N+1, done in N+2.
  - read: done in N+3, with bus_q valid from N+3.
- Back-to-back: a start in the DONE cycle is accepted, so a new request can issue every 2 (write) or 3 (read) cycles.
- bus_start while busy (ACCESS or WAIT) is ignored. It is not queued.
- Out-of-range offset:
  - write: no we asserted; done still pulses.
  - read: bus_q = 0; done still pulses.
- Non-selected memories keep their previous addr and d; the selected memory's addr and d hold after ACCESS until the next request.
- Any write enable is high for exactly one cycle per accepted in-range write.

Test Plan:
- Write VRAM32 addr 0x0005, data 0xDEADBEEF -> vram32_cpu_we high only in cycle N+1 with addr 5 and d 0xDEADBEEF; other we stay 0; bus_done in N+2.
- Read VRAM8 addr 0x8010 with the model returning 0xA5 -> bus_done in N+3, bus_q = 0x000000A5; bus_busy high in N+1..N+2.
- Write VRAMSPR addr 0xC0FF, data 0xFFFFFFFF, then read it back -> vramSPR_cpu_d = 0x1FF; read returns bus_q = 0x000001FF.
- Write VRAM322 offset 1056 (0x4420) -> no we toggles, done pulses; read of the same address -> bus_q = 0.
- Read issued in the DONE cycle of a prior write; bus_start pulsed during WAIT -> both complete in order; the WAIT-cycle start produces no extra transaction.
- Assert nreset low during ACCESS of a write -> we drops immediately, no done; after release, state is IDLE and all outputs are 0.
